// File: rtl/connect_arb.sv
// Round-robin arbiter for one shared drive/observe link: IDLE -> GRANT -> RELEASE,
// with a bounded hold time and a registered, owner-addressed observe path.
module connect_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] drive_in,
  output logic [N-1:0] gnt,
  output logic         link_en,
  output logic         link_drive,
  input  logic         link_observe,
  output logic         obs_q,
  output logic [N-1:0] obs_valid,
  output logic [1:0]   dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_obs_valid;
  logic            r_obs_q;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_hcnt;
  logic [PW-1:0]   w_winner;
  logic [N-1:0]    w_winner_oh;
  logic [N-1:0]    w_owner_oh;
  logic            w_any_req;
  logic            w_leave;

  // First requester at or above p, wrapping; scanned downward so the lowest offset wins.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    int            s;
    w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = int'(p) + i;
      if (s >= N) s = s - N;
      if (r[s[PW-1:0]]) w = PW'(s);
    end
    return w;
  endfunction

  assign w_any_req   = |req;
  assign w_winner    = rr_pick(req, r_ptr);
  assign w_winner_oh = {{(N-1){1'b0}}, 1'b1} << w_winner;
  assign w_owner_oh  = {{(N-1){1'b0}}, 1'b1} << r_owner;
  assign w_leave     = !req[r_owner] || (r_hcnt == HOLD_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = GRANT;
      GRANT:   if (w_leave) w_next_state = RELEASE;
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_obs_valid <= '0;
      r_obs_q     <= 1'b0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_hcnt      <= '0;
    end else begin
      r_state     <= w_next_state;
      r_obs_q     <= link_observe;
      r_obs_valid <= (r_state == GRANT) ? w_owner_oh : '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_gnt   <= w_winner_oh;
            r_hcnt  <= '0;
          end
        end
        GRANT: begin
          r_hcnt <= r_hcnt + 8'd1;
          if (w_leave) r_gnt <= '0;
        end
        RELEASE: begin
          // Pointer moves past the last owner so a forced release hands over fairly.
          r_ptr <= (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign link_en    = (r_state == GRANT);
  assign link_drive = (r_state == GRANT) && drive_in[r_owner];
  assign obs_q      = r_obs_q;
  assign obs_valid  = r_obs_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_connect_arb.sv
// Bench for connect_arb: vector table plus hand-written round-robin and reset sequences,
// outputs packed as {gnt, link_en, link_drive, obs_q, obs_valid}.
module tb_connect_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] drive_in;
  logic [3:0] gnt;
  logic       link_en;
  logic       link_drive;
  logic       link_observe;
  logic       obs_q;
  logic [3:0] obs_valid;
  logic [1:0] dbg_state;

  int pass_cnt;
  int total_cnt;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  drv;
    logic        obs;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  connect_arb #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .drive_in(drive_in), .gnt(gnt),
    .link_en(link_en), .link_drive(link_drive), .link_observe(link_observe),
    .obs_q(obs_q), .obs_valid(obs_valid), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ex(input logic [3:0] g, input logic en, input logic ld,
                                     input logic oq, input logic [3:0] ov);
    return {g, en, ld, oq, ov};
  endfunction

  function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic o,
                              input logic [10:0] e, input string nm);
    vec_t v;
    v.req = r; v.drv = d; v.obs = o; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  // scoreboard
  task automatic check(input string nm);
    logic [10:0] act;
    logic [10:0] e;
    act = {gnt, link_en, link_drive, obs_q, obs_valid};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected entry queued, got %b", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act === e) pass_cnt++;
      else $display("FAIL %s: got gnt/en/drv/obsq/obsv=%b required %b", nm, act, e);
    end
  endtask

  // driver: apply inputs on the falling edge, sample before the next rising edge
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic o,
                      input logic [10:0] e, input string nm);
    @(negedge clk);
    req = r; drive_in = d; link_observe = o;
    exp_q.push_back(e);
    #2;
    check(nm);
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] oh;
    logic [3:0] ov;
    logic [3:0] rq;
    int         o;
    pass_cnt = 0;
    total_cnt = 0;

    // single requester held 3 cycles
    add(4'b0001, 4'b0001, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "s_idle");
    add(4'b0001, 4'b0001, 1'b0, ex(4'b0001, 1, 1, 0, 4'b0000), "s_grant1");
    add(4'b0001, 4'b0000, 1'b0, ex(4'b0001, 1, 0, 0, 4'b0001), "s_grant2");
    add(4'b0000, 4'b0001, 1'b0, ex(4'b0001, 1, 1, 0, 4'b0001), "s_grant3");
    add(4'b0000, 4'b0001, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0001), "s_release");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "s_idle_end");
    // one-cycle pulse on requester 3
    add(4'b1000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "p_idle");
    add(4'b0000, 4'b1000, 1'b0, ex(4'b1000, 1, 1, 0, 4'b0000), "p_grant");
    add(4'b0000, 4'b1000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b1000), "p_release");
    add(4'b0000, 4'b1000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "p_idle_end");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "p_stay_idle");
    // owner 2, requester 3 arrives mid-grant
    add(4'b0100, 4'b1011, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "m_idle");
    add(4'b0100, 4'b1011, 1'b0, ex(4'b0100, 1, 0, 0, 4'b0000), "m_grant");
    add(4'b1100, 4'b0100, 1'b0, ex(4'b0100, 1, 1, 0, 4'b0100), "m_req3_rise");
    add(4'b1100, 4'b1011, 1'b0, ex(4'b0100, 1, 0, 0, 4'b0100), "m_hold");
    add(4'b1000, 4'b1011, 1'b0, ex(4'b0100, 1, 0, 0, 4'b0100), "m_req2_drop");
    add(4'b1000, 4'b1111, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0100), "m_release");
    add(4'b1000, 4'b1111, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "m_gap_idle");
    add(4'b1000, 4'b0111, 1'b0, ex(4'b1000, 1, 0, 0, 4'b0000), "m_grant3");
    add(4'b0000, 4'b1000, 1'b0, ex(4'b1000, 1, 1, 0, 4'b1000), "m_grant3_last");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b1000), "m_release3");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "m_idle_end");
    // observe path during a grant to requester 1
    add(4'b0010, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "o_idle");
    add(4'b0010, 4'b0010, 1'b1, ex(4'b0010, 1, 1, 0, 4'b0000), "o_obs1");
    add(4'b0010, 4'b0000, 1'b0, ex(4'b0010, 1, 0, 1, 4'b0010), "o_obs0");
    add(4'b0010, 4'b0000, 1'b1, ex(4'b0010, 1, 0, 0, 4'b0010), "o_obs1b");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0010, 1, 0, 1, 4'b0010), "o_last");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0010), "o_release");
    add(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "o_idle_end");

    // reset: outputs forced low even with the link observe bit and requests high
    rst = 1'b1; req = 4'b1111; drive_in = 4'b1111; link_observe = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ex(4'b0000, 0, 0, 0, 4'b0000));
    check("rst_held1");
    @(posedge clk); #1;
    exp_q.push_back(ex(4'b0000, 0, 0, 0, 4'b0000));
    check("rst_held2");
    @(negedge clk);
    req = 4'b0000; drive_in = 4'b0000; link_observe = 1'b0; rst = 1'b0;

    // all four requesting: order 0,1,2,3,0, MAX_HOLD cycles each, 2-cycle gaps
    step(4'b1111, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "rr_idle0");
    for (int g = 0; g < 5; g++) begin
      o  = g % 4;
      oh = 4'b0001 << o;
      rq = (g == 4) ? 4'b0000 : 4'b1111;
      for (int c = 0; c < 8; c++) begin
        d  = 4'($urandom_range(0, 15));
        ov = (c == 0) ? 4'b0000 : oh;
        step(4'b1111, d, 1'b0, ex(oh, 1'b1, d[o], 1'b0, ov), "rr_grant");
      end
      step(rq, 4'($urandom_range(0, 15)), 1'b0, ex(4'b0000, 0, 0, 0, oh), "rr_release");
      step(rq, 4'($urandom_range(0, 15)), 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "rr_gap_idle");
    end

    foreach (vecs[k]) step(vecs[k].req, vecs[k].drv, vecs[k].obs, vecs[k].exp, vecs[k].name);

    // asynchronous reset in the middle of a grant
    step(4'b0001, 4'b0001, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "r_idle");
    step(4'b0001, 4'b0001, 1'b0, ex(4'b0001, 1, 1, 0, 4'b0000), "r_grant");
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(ex(4'b0000, 0, 0, 0, 4'b0000));
    check("r_async_drop");
    @(posedge clk); #1;
    exp_q.push_back(ex(4'b0000, 0, 0, 0, 4'b0000));
    check("r_held");
    rst = 1'b0; req = 4'b0110;
    step(4'b0110, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0000), "r_post_idle");
    step(4'b0110, 4'b0000, 1'b0, ex(4'b0010, 1, 0, 0, 4'b0000), "r_first_owner1");
    step(4'b0000, 4'b0010, 1'b0, ex(4'b0010, 1, 1, 0, 4'b0010), "r_owner1_last");
    step(4'b0000, 4'b0000, 1'b0, ex(4'b0000, 0, 0, 0, 4'b0010), "r_release");

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/connect_arb.md
CONNECT_ARB -- requirements
Module: connect_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesters sharing the link (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive grant cycles per ownership (2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req  input  N  per-requester access request, level-sensitive.
REQ-006 SHALL have port drive_in  input  N  per-requester drive bit, forwarded only for the owner.
REQ-007 SHALL have port gnt  output  N  registered grant, one-hot or zero.
REQ-008 SHALL have port link_en  output  1  high when the shared link is owned (GRANT state).
REQ-009 SHALL have port link_drive  output  1  drive bit onto the shared drive/observe link.
REQ-010 SHALL have port link_observe  input  1  observe bit returned by the shared link.
REQ-011 SHALL have port obs_q  output  1  registered copy of link_observe.
REQ-012 SHALL have port obs_valid  output  N  one-hot qualifier for obs_q, addressed to the owner.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-014 SHALL, in IDLE with req != 0, select the winner round-robin, searching upward from pointer ptr with wrap from N-1 to 0, and enter GRANT next edge with gnt = one-hot(winner).
REQ-015 SHALL, in IDLE with req == 0, remain in IDLE with gnt = 0.
REQ-016 SHALL hold owner and gnt constant throughout GRANT; req changes of other requesters SHALL NOT affect the current grant.
REQ-017 SHALL drive link_en = 1 and link_drive = drive_in[owner] combinationally in GRANT, and link_en = 0, link_drive = 0 in IDLE and RELEASE.
REQ-018 SHALL maintain hold counter hcnt: cleared on entry to GRANT, incremented on each GRANT cycle.
REQ-019 SHALL leave GRANT for RELEASE when req[owner] is sampled low or when hcnt == MAX_HOLD-1; a grant therefore lasts 1..MAX_HOLD cycles.
REQ-020 SHALL spend exactly one cycle in RELEASE (turnaround) with gnt = 0, set ptr = (owner+1) mod N, then go to IDLE.
REQ-021 SHALL ensure a requester still holding req after a forced (MAX_HOLD) release competes normally and does not win again while any other requester is asserted.
REQ-022 SHALL register obs_q <= link_observe every cycle.
REQ-023 SHALL assert obs_valid[owner] in the cycle after each GRANT cycle, and deassert it otherwise; obs_valid latency = 1 cycle.
REQ-024 SHALL guarantee gnt and obs_valid are each one-hot or zero in every cycle.
REQ-025 SHALL guarantee minimum idle gap between two ownerships: 2 cycles (RELEASE + IDLE).
REQ-026 SHALL give requester 0 priority when ptr = 0 and several requests arrive simultaneously.

Reset
REQ-027 SHALL, while rst is high, force state = IDLE, gnt = 0, obs_valid = 0, obs_q = 0, hcnt = 0, ptr = 0, independent of clk.
REQ-028 SHALL, on rst asserted mid-GRANT, drop link_en and gnt immediately (asynchronously) with no RELEASE cycle.
REQ-029 SHALL begin arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-030 SHALL cover: single requester, req = 0001 held 3 cycles -> gnt = 0001 for 3 cycles, then RELEASE, link_drive follows drive_in[0].
REQ-031 SHALL cover: req = 1111 held constant, N=4 -> grant order 0,1,2,3,0, each held MAX_HOLD = 8 cycles, separated by 2-cycle gaps.
REQ-032 SHALL cover: owner 2 granted, req[3] rises mid-grant -> gnt stays 0100 until req[2] drops, then 1000 after 2 cycles.
REQ-033 SHALL cover: link_observe toggled 1,0,1 during a grant to requester 1 -> obs_q = 1,0,1 with obs_valid = 0010, each one cycle late.
REQ-034 SHALL cover: rst pulsed during GRANT -> gnt = 0, link_en = 0 before the next edge; after release, req = 0110 grants requester 1 first.
REQ-035 SHALL cover: req pulse of one cycle on requester 3 in IDLE -> exactly one GRANT cycle, then RELEASE, then IDLE.
